bc_control_unit: RTL and testbench
==================================

# bc_control_unit

Timing and control unit for the Basic Computer datapath. It holds the sequence counter (T0..T6), decodes the instruction register and drives the 3-bit common-bus select plus every register load/increment/clear strobe, memory read/write and ALU operation for fetch, decode and execute. It is the sole owner of the bus select, so exactly one source drives the bus each cycle.

## Interface
Parameters:
- SC_W, 3, sequence-counter width (T0..T7 encodable; T7 unused)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- ir  in  16  IR contents: [15]=I, [14:12]=opcode, [11:0]=address/B-bits
- ac_zero, ac_msb, dr_zero, e_val  in  1 each  datapath status, combinational from current register values
- fgi, fgo  in  1 each  I/O flags
- bus_sel  out  3  0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory
- ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc, ac_ld, ac_inc, ac_clr, ir_ld, tr_ld  out  1 each  register strobes
- mem_rd, mem_wr  out  1 each  memory strobes, address = AR
- alu_op  out  3  0 AND, 1 ADD, 2 PASS_DR, 3 CMA, 4 SHR, 5 SHL, 6 INPR
- e_clr, e_cmp, inp_clr, out_ld  out  1 each
- sc  out  3  current T state
- halted  out  1  HLT executed

## Operation
- Strobes are combinational from sc, ir, internal flops (I, halted, IEN, R) and status. All outputs are 0 when no rule applies.
- Fetch: T0 bus_sel=2, ar_ld. T1 bus_sel=7, mem_rd, ir_ld, pc_inc. T2 bus_sel=5, ar_ld; I flop <= ir[15].
- T3: if opcode!=7 and I=1, bus_sel=7, mem_rd, ar_ld (indirect). If opcode!=7 and I=0, do nothing. If opcode=7, execute and clear SC.
- Memory reference (T4 onward): AND/ADD/LDA T4 bus_sel=7, mem_rd, dr_ld; T5 ac_ld with alu_op 0/1/2, clear SC. STA T4 bus_sel=4, mem_wr, clear SC. BUN T4 bus_sel=1, pc_ld, clear SC. BSA T4 bus_sel=2, mem_wr, ar_inc; T5 bus_sel=1, pc_ld, clear SC. ISZ T4 read to DR; T5 dr_inc; T6 bus_sel=3, mem_wr, pc_inc if dr_zero, clear SC.
- Register reference (opcode 7, I=0, T3), keyed on ir[11:0]: B11 CLA ac_clr, B10 CLE e_clr, B9 CMA ac_ld+alu 3, B8 CME e_cmp, B7 CIR ac_ld+alu 4, B6 CIL ac_ld+alu 5, B5 INC ac_inc, B4 SPA, B3 SNA, B2 SZA, B1 SZE (pc_inc on !ac_msb / ac_msb / ac_zero / !e_val), B0 HLT sets halted.
- More than one B-bit set: every decoded strobe asserts together. alu_op takes the lowest-numbered code among those selected.
- Halted: SC is held at 0 and all strobes are 0. Only reset clears halted.

## Timing
- Reset state: sc=0, halted=0, I=0, IEN=0, R=0. All strobes are 0 during any cycle with rst_n=0.
- Reset mid-instruction abandons that instruction. Fetch T0 strobes assert in the first cycle after rst_n returns high.
- Instruction lengths in cycles: register reference 4, STA/BUN 5, AND/ADD/LDA/BSA 6, ISZ 7. Indirect addressing adds no cycles.
- SC increments every cycle unless cleared. A clear at Tn makes the next cycle T0.

## Configuration
- Macro: BC_INTERRUPT_EN.
- When defined:
  - Opcode 7 with I=1 at T3 executes I/O: B11 INP (ac_ld, alu 6, inp_clr), B10 OUT (bus_sel=4, out_ld), B9 SKI (pc_inc if fgi), B8 SKO (pc_inc if fgo), B7 ION (IEN<=1), B6 IOF (IEN<=0).
  - R <= 1 in any cycle where sc is not T0, T1 or T2 and IEN and (fgi|fgo).
  - When R=1, the next T0 starts an interrupt cycle instead of a fetch: T0 ar_clr, bus_sel=2, tr_ld; T1 bus_sel=6, mem_wr, pc_clr; T2 pc_inc, IEN<=0, R<=0, clear SC.
- When undefined:
  - Opcode 7 with I=1 is a 4-cycle NOP.
  - fgi and fgo are ignored; inp_clr and out_ld are tied to 0.

## Structure
- Package bc_ctrl_pkg holds the bus-select codes, alu_op codes, opcode constants and the B-bit indices.
- Sub-module bc_seq_counter: SC_W-bit counter with increment, synchronous clear and hold inputs, plus a one-hot T-state decode output.

## Test plan
- Reset, then AR, PC and memory models with PC=0x010 and M[0x010]=0x2040 (LDA 0x040), M[0x040]=0x1234: bus_sel sequence is 2,7,5,0,7,0; ac_ld with alu_op=2 at T5; sc returns to 0 after 6 cycles.
- Indirect ISZ, ir=0xE050, M[0x050]=0x0060, DR becomes 0 after increment: ar_ld from memory at T3; mem_wr with bus_sel=3 at T6; pc_inc at T6.
- ir=0x7001 (HLT): halted=1 after T3, sc stays 0 and all strobes stay 0 for 20 cycles; rst_n=0 for one cycle clears halted.
- ir=0x7004 (SZA) with ac_zero=1, then with ac_zero=0: pc_inc at T3 only in the first case.
- rst_n=0 at T5 of an ADD: the following cycle has sc=0 and no ac_ld.
- With BC_INTERRUPT_EN: ION, then fgi=1 during T3: R is set; next T0 shows ar_clr, tr_ld, bus_sel=2; T1 mem_wr with bus_sel=6 and pc_clr; T2 pc_inc; IEN=0 afterwards.

Source files
------------

// File: rtl/bc_ctrl_pkg.sv
// Shared constants for the Basic Computer control unit: bus-select and ALU codes,
// opcodes, instruction B-bit positions, T-state indices and the register-reference ALU selector.
package bc_ctrl_pkg;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [2:0] ALU_AND     = 3'd0;
    localparam logic [2:0] ALU_ADD     = 3'd1;
    localparam logic [2:0] ALU_PASS_DR = 3'd2;
    localparam logic [2:0] ALU_CMA     = 3'd3;
    localparam logic [2:0] ALU_SHR     = 3'd4;
    localparam logic [2:0] ALU_SHL     = 3'd5;
    localparam logic [2:0] ALU_INPR    = 3'd6;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    localparam int unsigned B_CLA = 32'd11;
    localparam int unsigned B_CLE = 32'd10;
    localparam int unsigned B_CMA = 32'd9;
    localparam int unsigned B_CME = 32'd8;
    localparam int unsigned B_CIR = 32'd7;
    localparam int unsigned B_CIL = 32'd6;
    localparam int unsigned B_INC = 32'd5;
    localparam int unsigned B_SPA = 32'd4;
    localparam int unsigned B_SNA = 32'd3;
    localparam int unsigned B_SZA = 32'd2;
    localparam int unsigned B_SZE = 32'd1;
    localparam int unsigned B_HLT = 32'd0;

    localparam int unsigned B_INP = 32'd11;
    localparam int unsigned B_OUT = 32'd10;
    localparam int unsigned B_SKI = 32'd9;
    localparam int unsigned B_SKO = 32'd8;
    localparam int unsigned B_ION = 32'd7;
    localparam int unsigned B_IOF = 32'd6;

    localparam int unsigned T0 = 32'd0;
    localparam int unsigned T1 = 32'd1;
    localparam int unsigned T2 = 32'd2;
    localparam int unsigned T3 = 32'd3;
    localparam int unsigned T4 = 32'd4;
    localparam int unsigned T5 = 32'd5;
    localparam int unsigned T6 = 32'd6;
    localparam int unsigned T7 = 32'd7;

    // Several AC-modifying B-bits may be set at once; the lowest ALU code wins.
    function automatic logic [2:0] rr_alu_op(input logic [11:0] b);
        logic [2:0] op;
        if (b[B_CMA]) begin
            op = ALU_CMA;
        end else if (b[B_CIR]) begin
            op = ALU_SHR;
        end else if (b[B_CIL]) begin
            op = ALU_SHL;
        end else begin
            op = ALU_AND;
        end
        return op;
    endfunction

endpackage

// File: rtl/bc_seq_counter.sv
// Sequence counter with synchronous clear and hold, plus one-hot T-state decode.
module bc_seq_counter
    import bc_ctrl_pkg::*;
#(
    parameter int SC_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    input  logic                   clr,
    input  logic                   hold,
    output logic [SC_W-1:0]        sc,
    output logic [(1<<SC_W)-1:0]   t_state
);

    logic [SC_W-1:0] sc_r;

    // Counter register: clear beats hold, hold beats increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc_r <= '0;
        end else if (clr) begin
            sc_r <= '0;
        end else if (hold) begin
            sc_r <= sc_r;
        end else if (inc) begin
            sc_r <= sc_r + SC_W'(1);
        end else begin
            sc_r <= sc_r;
        end
    end

    // One-hot decode of the current T state
    always_comb begin
        t_state       = '0;
        t_state[sc_r] = 1'b1;
    end

    assign sc = sc_r;

endmodule

// File: rtl/bc_control_unit.sv
// Basic Computer timing/control unit: fetch, decode and execute strobes from SC and IR.
// Optional I/O instructions and interrupt cycle are built when BC_INTERRUPT_EN is defined.
module bc_control_unit
    import bc_ctrl_pkg::*;
#(
    parameter int SC_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     ir,
    input  logic            ac_zero,
    input  logic            ac_msb,
    input  logic            dr_zero,
    input  logic            e_val,
    input  logic            fgi,
    input  logic            fgo,
    output logic [2:0]      bus_sel,
    output logic            ar_ld,
    output logic            ar_inc,
    output logic            ar_clr,
    output logic            pc_ld,
    output logic            pc_inc,
    output logic            pc_clr,
    output logic            dr_ld,
    output logic            dr_inc,
    output logic            ac_ld,
    output logic            ac_inc,
    output logic            ac_clr,
    output logic            ir_ld,
    output logic            tr_ld,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [2:0]      alu_op,
    output logic            e_clr,
    output logic            e_cmp,
    output logic            inp_clr,
    output logic            out_ld,
    output logic [SC_W-1:0] sc,
    output logic            halted
);

    logic [(1<<SC_W)-1:0] t_s;
    logic [2:0]           opcode_s;
    logic [11:0]          b_s;
    logic                 i_r;
    logic                 halted_r;
    logic                 r_r;
    logic                 io_en_s;
    logic                 sc_clr_s;
    logic                 i_ld_s;
    logic                 halt_set_s;
    logic                 ien_set_s;
    logic                 ien_clr_s;
    logic                 r_clr_s;
    logic                 unused_s;

    assign opcode_s = ir[14:12];
    assign b_s      = ir[11:0];
    assign halted   = halted_r;

    bc_seq_counter #(.SC_W(SC_W)) u_sc (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (1'b1),
        .clr     (sc_clr_s),
        .hold    (halted_r),
        .sc      (sc),
        .t_state (t_s)
    );

    // Strobe decode; everything stays low in reset and once halted
    always_comb begin
        bus_sel    = BUS_NONE;
        alu_op     = ALU_AND;
        {ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr}  = 6'b0;
        {dr_ld, dr_inc, ac_ld, ac_inc, ac_clr}          = 5'b0;
        {ir_ld, tr_ld, mem_rd, mem_wr}                  = 4'b0;
        {e_clr, e_cmp, inp_clr, out_ld}                 = 4'b0;
        sc_clr_s   = 1'b0;
        i_ld_s     = 1'b0;
        halt_set_s = 1'b0;
        ien_set_s  = 1'b0;
        ien_clr_s  = 1'b0;
        r_clr_s    = 1'b0;
        if (!rst_n || halted_r) begin
            sc_clr_s = 1'b0;
        end else if (r_r && (t_s[T0] || t_s[T1] || t_s[T2])) begin
            // Interrupt cycle: save PC at M[0], resume at 1
            case (1'b1)
                t_s[T0]: begin bus_sel = BUS_PC; ar_clr = 1'b1; tr_ld = 1'b1; end
                t_s[T1]: begin bus_sel = BUS_TR; mem_wr = 1'b1; pc_clr = 1'b1; end
                t_s[T2]: begin pc_inc = 1'b1; ien_clr_s = 1'b1; r_clr_s = 1'b1; sc_clr_s = 1'b1; end
                default: sc_clr_s = 1'b0;
            endcase
        end else begin
            case (1'b1)
                t_s[T0]: begin bus_sel = BUS_PC; ar_ld = 1'b1; end
                t_s[T1]: begin bus_sel = BUS_MEM; mem_rd = 1'b1; ir_ld = 1'b1; pc_inc = 1'b1; end
                t_s[T2]: begin bus_sel = BUS_IR; ar_ld = 1'b1; i_ld_s = 1'b1; end
                t_s[T3]: begin
                    if (opcode_s == OP_REG) begin
                        sc_clr_s = 1'b1;
                        if (i_r) begin
                            ac_ld     = io_en_s & b_s[B_INP];
                            inp_clr   = io_en_s & b_s[B_INP];
                            alu_op    = (io_en_s & b_s[B_INP]) ? ALU_INPR : ALU_AND;
                            bus_sel   = (io_en_s & b_s[B_OUT]) ? BUS_AC : BUS_NONE;
                            out_ld    = io_en_s & b_s[B_OUT];
                            pc_inc    = io_en_s & ((b_s[B_SKI] & fgi) | (b_s[B_SKO] & fgo));
                            ien_set_s = io_en_s & b_s[B_ION];
                            ien_clr_s = io_en_s & b_s[B_IOF];
                        end else begin
                            ac_clr     = b_s[B_CLA];
                            e_clr      = b_s[B_CLE];
                            ac_ld      = b_s[B_CMA] | b_s[B_CIR] | b_s[B_CIL];
                            alu_op     = rr_alu_op(b_s);
                            e_cmp      = b_s[B_CME];
                            ac_inc     = b_s[B_INC];
                            pc_inc     = (b_s[B_SPA] & ~ac_msb) | (b_s[B_SNA] & ac_msb) |
                                         (b_s[B_SZA] & ac_zero) | (b_s[B_SZE] & ~e_val);
                            halt_set_s = b_s[B_HLT];
                        end
                    end else begin
                        bus_sel = i_r ? BUS_MEM : BUS_NONE;
                        mem_rd  = i_r;
                        ar_ld   = i_r;
                    end
                end
                t_s[T4]: begin
                    case (opcode_s)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin bus_sel = BUS_MEM; mem_rd = 1'b1; dr_ld = 1'b1; end
                        OP_STA:  begin bus_sel = BUS_AC; mem_wr = 1'b1; sc_clr_s = 1'b1; end
                        OP_BUN:  begin bus_sel = BUS_AR; pc_ld = 1'b1; sc_clr_s = 1'b1; end
                        OP_BSA:  begin bus_sel = BUS_PC; mem_wr = 1'b1; ar_inc = 1'b1; end
                        default: sc_clr_s = 1'b0;
                    endcase
                end
                t_s[T5]: begin
                    case (opcode_s)
                        OP_AND:  begin ac_ld = 1'b1; alu_op = ALU_AND; sc_clr_s = 1'b1; end
                        OP_ADD:  begin ac_ld = 1'b1; alu_op = ALU_ADD; sc_clr_s = 1'b1; end
                        OP_LDA:  begin ac_ld = 1'b1; alu_op = ALU_PASS_DR; sc_clr_s = 1'b1; end
                        OP_BSA:  begin bus_sel = BUS_AR; pc_ld = 1'b1; sc_clr_s = 1'b1; end
                        OP_ISZ:  dr_inc = 1'b1;
                        default: sc_clr_s = 1'b0;
                    endcase
                end
                t_s[T6]: begin
                    if (opcode_s == OP_ISZ) begin
                        bus_sel  = BUS_DR;
                        mem_wr   = 1'b1;
                        pc_inc   = dr_zero;
                        sc_clr_s = 1'b1;
                    end else begin
                        sc_clr_s = 1'b0;
                    end
                end
                default: sc_clr_s = 1'b0;
            endcase
        end
    end

    // Indirect-bit capture at T2 and sticky halt flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_r      <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            i_r      <= i_ld_s ? ir[15] : i_r;
            halted_r <= halted_r | halt_set_s;
        end
    end

`ifdef BC_INTERRUPT_EN
    logic ien_r;
    logic r_set_s;

    assign io_en_s  = 1'b1;
    assign r_set_s  = ~halted_r & ~(t_s[T0] | t_s[T1] | t_s[T2]) & ien_r & (fgi | fgo);
    assign unused_s = t_s[T7];

    // Interrupt enable and pending-request flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ien_r <= 1'b0;
            r_r   <= 1'b0;
        end else begin
            if (ien_clr_s) begin
                ien_r <= 1'b0;
            end else if (ien_set_s) begin
                ien_r <= 1'b1;
            end else begin
                ien_r <= ien_r;
            end
            if (r_clr_s) begin
                r_r <= 1'b0;
            end else if (r_set_s) begin
                r_r <= 1'b1;
            end else begin
                r_r <= r_r;
            end
        end
    end
`else
    assign io_en_s  = 1'b0;
    assign r_r      = 1'b0;
    assign unused_s = ^{ien_set_s, ien_clr_s, r_clr_s, t_s[T7]};
`endif

endmodule

// File: tb/tb_bc_control_unit.sv
// Scoreboard bench for bc_control_unit: a small datapath/memory model runs a directed program,
// the stimulus queues hand-computed per-cycle strobes and a negedge monitor compares them.
module tb_bc_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ir;
    logic        ac_zero, ac_msb, dr_zero, e_val, fgi, fgo;
    logic [2:0]  bus_sel, alu_op, sc;
    logic        ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc;
    logic        ac_ld, ac_inc, ac_clr, ir_ld, tr_ld, mem_rd, mem_wr;
    logic        e_clr, e_cmp, inp_clr, out_ld, halted;

    bc_control_unit dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .ac_zero(ac_zero), .ac_msb(ac_msb),
        .dr_zero(dr_zero), .e_val(e_val), .fgi(fgi), .fgo(fgo), .bus_sel(bus_sel),
        .ar_ld(ar_ld), .ar_inc(ar_inc), .ar_clr(ar_clr), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .pc_clr(pc_clr), .dr_ld(dr_ld), .dr_inc(dr_inc), .ac_ld(ac_ld), .ac_inc(ac_inc),
        .ac_clr(ac_clr), .ir_ld(ir_ld), .tr_ld(tr_ld), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .alu_op(alu_op), .e_clr(e_clr), .e_cmp(e_cmp), .inp_clr(inp_clr), .out_ld(out_ld),
        .sc(sc), .halted(halted)
    );

    always #5 clk = ~clk;

    localparam logic [18:0] AR_LD  = 19'd1 << 18;
    localparam logic [18:0] AR_INC = 19'd1 << 17;
    localparam logic [18:0] AR_CLR = 19'd1 << 16;
    localparam logic [18:0] PC_LD  = 19'd1 << 15;
    localparam logic [18:0] PC_INC = 19'd1 << 14;
    localparam logic [18:0] PC_CLR = 19'd1 << 13;
    localparam logic [18:0] DR_LD  = 19'd1 << 12;
    localparam logic [18:0] DR_INC = 19'd1 << 11;
    localparam logic [18:0] AC_LD  = 19'd1 << 10;
    localparam logic [18:0] AC_INC = 19'd1 << 9;
    localparam logic [18:0] AC_CLR = 19'd1 << 8;
    localparam logic [18:0] IR_LD  = 19'd1 << 7;
    localparam logic [18:0] TR_LD  = 19'd1 << 6;
    localparam logic [18:0] MEM_RD = 19'd1 << 5;
    localparam logic [18:0] MEM_WR = 19'd1 << 4;
    localparam logic [18:0] INP_CL = 19'd1 << 1;
    localparam logic [18:0] OUT_LD = 19'd1 << 0;
    localparam logic [18:0] NONE   = 19'd0;

    // Datapath model
    logic [15:0] mem [0:4095];
    logic [11:0] ar_m = 12'h000, pc_m = 12'h010;
    logic [15:0] dr_m = 16'h0000, ac_m = 16'h0000, ir_m = 16'h0000, tr_m = 16'h0000;
    logic        e_m = 1'b0;
    logic [15:0] bus_v, alu_v;

    always_comb begin
        case (bus_sel)
            3'd1: bus_v = {4'h0, ar_m};
            3'd2: bus_v = {4'h0, pc_m};
            3'd3: bus_v = dr_m;
            3'd4: bus_v = ac_m;
            3'd5: bus_v = ir_m;
            3'd6: bus_v = tr_m;
            3'd7: bus_v = mem[ar_m];
            default: bus_v = 16'h0000;
        endcase
        case (alu_op)
            3'd0: alu_v = ac_m & dr_m;
            3'd1: alu_v = ac_m + dr_m;
            3'd2: alu_v = dr_m;
            3'd3: alu_v = ~ac_m;
            3'd4: alu_v = {e_m, ac_m[15:1]};
            3'd5: alu_v = {ac_m[14:0], e_m};
            3'd6: alu_v = {ac_m[15:8], 8'h00};
            default: alu_v = ac_m;
        endcase
    end

    assign ir      = ir_m;
    assign ac_zero = (ac_m == 16'h0000);
    assign ac_msb  = ac_m[15];
    assign dr_zero = (dr_m == 16'h0000);
    assign e_val   = e_m;

    always @(posedge clk) begin
        if (ar_clr) ar_m <= 12'h000; else if (ar_ld) ar_m <= bus_v[11:0]; else if (ar_inc) ar_m <= ar_m + 12'h001;
        if (pc_clr) pc_m <= 12'h000; else if (pc_ld) pc_m <= bus_v[11:0]; else if (pc_inc) pc_m <= pc_m + 12'h001;
        if (dr_ld) dr_m <= bus_v; else if (dr_inc) dr_m <= dr_m + 16'h0001;
        if (ac_clr) ac_m <= 16'h0000; else if (ac_inc) ac_m <= ac_m + 16'h0001; else if (ac_ld) ac_m <= alu_v;
        if (ir_ld) ir_m <= bus_v;
        if (tr_ld) tr_m <= bus_v;
        if (mem_wr) mem[ar_m] <= bus_v;
        if (e_clr) e_m <= 1'b0; else if (e_cmp) e_m <= ~e_m;
    end

    // Scoreboard
    typedef struct packed {
        logic [63:0] tag;
        logic [2:0]  sc;
        logic [2:0]  bus;
        logic [18:0] str;
        logic [2:0]  alu;
        logic        halt;
        logic        chk_sh;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [18:0] mon_act;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = {ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc, ac_ld, ac_inc,
                       ac_clr, ir_ld, tr_ld, mem_rd, mem_wr, e_clr, e_cmp, inp_clr, out_ld};
            n_checks++;
            if (mon_act !== mon_e.str || bus_sel !== mon_e.bus || alu_op !== mon_e.alu ||
                (mon_e.chk_sh && (sc !== mon_e.sc || halted !== mon_e.halt))) begin
                n_errors++;
                $display("FAIL %s: got sc=%0d bus=%0d str=%h alu=%0d halt=%b, expected sc=%0d bus=%0d str=%h alu=%0d halt=%b",
                         mon_e.tag, sc, bus_sel, mon_act, alu_op, halted,
                         mon_e.sc, mon_e.bus, mon_e.str, mon_e.alu, mon_e.halt);
            end
        end
    end

    task automatic cyc(input logic [63:0] tag, input logic [2:0] sc_e, input logic [2:0] bus_e,
                       input logic [18:0] str_e, input logic [2:0] alu_e, input logic halt_e,
                       input logic chk_sh);
        exp_t e;
        e = '{tag: tag, sc: sc_e, bus: bus_e, str: str_e, alu: alu_e, halt: halt_e, chk_sh: chk_sh};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch();
        cyc("F_T0", 3'd0, 3'd2, AR_LD, 3'd0, 1'b0, 1'b1);
        cyc("F_T1", 3'd1, 3'd7, MEM_RD | IR_LD | PC_INC, 3'd0, 1'b0, 1'b1);
        cyc("F_T2", 3'd2, 3'd5, AR_LD, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic check_val(input logic [63:0] tag, input logic [15:0] act, input logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    logic [15:0] ac_before;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h010] = 16'h2040;   // LDA 040
        mem[12'h011] = 16'hE050;   // ISZ I 050
        mem[12'h012] = 16'h7001;   // HLT (skipped)
        mem[12'h013] = 16'h7800;   // CLA
        mem[12'h014] = 16'h7004;   // SZA -> skip
        mem[12'h015] = 16'h7001;   // HLT (skipped)
        mem[12'h016] = 16'h7020;   // INC
        mem[12'h017] = 16'h7004;   // SZA -> no skip
        mem[12'h018] = 16'hF080;   // ION (NOP without interrupts)
        mem[12'h019] = 16'hFC00;   // INP|OUT (NOP without interrupts)
        mem[12'h01A] = 16'h1041;   // ADD 041, reset at T5
        mem[12'h01B] = 16'h7001;   // HLT
        mem[12'h001] = 16'h401A;   // interrupt service: BUN 01A
        mem[12'h040] = 16'h1234;
        mem[12'h041] = 16'h0001;
        mem[12'h050] = 16'h0060;
        mem[12'h060] = 16'hFFFF;
        rst_n = 1'b0; fgi = 1'b0; fgo = 1'b0;
        @(posedge clk); #1;
        cyc("RESET", 3'd0, 3'd0, NONE, 3'd0, 1'b0, 1'b1);
        rst_n = 1'b1;

        // LDA 040
        fetch();
        cyc("LDA_T3", 3'd3, 3'd0, NONE, 3'd0, 1'b0, 1'b1);
        cyc("LDA_T4", 3'd4, 3'd7, MEM_RD | DR_LD, 3'd0, 1'b0, 1'b1);
        cyc("LDA_T5", 3'd5, 3'd0, AC_LD, 3'd2, 1'b0, 1'b1);
        check_val("LDA_AC", ac_m, 16'h1234);

        // ISZ I 050
        fetch();
        cyc("ISZ_T3", 3'd3, 3'd7, MEM_RD | AR_LD, 3'd0, 1'b0, 1'b1);
        cyc("ISZ_T4", 3'd4, 3'd7, MEM_RD | DR_LD, 3'd0, 1'b0, 1'b1);
        cyc("ISZ_T5", 3'd5, 3'd0, DR_INC, 3'd0, 1'b0, 1'b1);
        cyc("ISZ_T6", 3'd6, 3'd3, MEM_WR | PC_INC, 3'd0, 1'b0, 1'b1);
        check_val("ISZ_MEM", mem[12'h060], 16'h0000);
        check_val("ISZ_PC", {4'h0, pc_m}, 16'h0013);

        fetch();
        cyc("CLA_T3", 3'd3, 3'd0, AC_CLR, 3'd0, 1'b0, 1'b1);
        fetch();
        cyc("SZA1_T3", 3'd3, 3'd0, PC_INC, 3'd0, 1'b0, 1'b1);
        fetch();
        cyc("INC_T3", 3'd3, 3'd0, AC_INC, 3'd0, 1'b0, 1'b1);
        fetch();
        cyc("SZA0_T3", 3'd3, 3'd0, NONE, 3'd0, 1'b0, 1'b1);
        fetch();
        cyc("F080_T3", 3'd3, 3'd0, NONE, 3'd0, 1'b0, 1'b1);
        fetch();
`ifdef BC_INTERRUPT_EN
        fgi = 1'b1;
        cyc("IO_T3", 3'd3, 3'd4, AC_LD | INP_CL | OUT_LD, 3'd6, 1'b0, 1'b1);
        fgi = 1'b0;
        cyc("INT_T0", 3'd0, 3'd2, AR_CLR | TR_LD, 3'd0, 1'b0, 1'b1);
        cyc("INT_T1", 3'd1, 3'd6, MEM_WR | PC_CLR, 3'd0, 1'b0, 1'b1);
        cyc("INT_T2", 3'd2, 3'd0, PC_INC, 3'd0, 1'b0, 1'b1);
        check_val("INT_SAVE", mem[12'h000], 16'h001A);
        fetch();
        fgi = 1'b1;
        cyc("BUN_T3", 3'd3, 3'd0, NONE, 3'd0, 1'b0, 1'b1);
        cyc("BUN_T4", 3'd4, 3'd1, PC_LD, 3'd0, 1'b0, 1'b1);
        fgi = 1'b0;
        check_val("BUN_PC", {4'h0, pc_m}, 16'h001A);
`else
        fgi = 1'b1; fgo = 1'b1;
        cyc("IO_T3", 3'd3, 3'd0, NONE, 3'd0, 1'b0, 1'b1);
        fgi = 1'b0; fgo = 1'b0;
`endif
        // ADD abandoned by reset at T5
        ac_before = ac_m;
        fetch();
        cyc("ADD_T3", 3'd3, 3'd0, NONE, 3'd0, 1'b0, 1'b1);
        cyc("ADD_T4", 3'd4, 3'd7, MEM_RD | DR_LD, 3'd0, 1'b0, 1'b1);
        rst_n = 1'b0;
        cyc("ADD_RST", 3'd5, 3'd0, NONE, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check_val("ADD_AC", ac_m, ac_before);

        // HLT at 01B
        fetch();
        cyc("HLT_T3", 3'd3, 3'd0, NONE, 3'd0, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            cyc("HALTED", 3'd0, 3'd0, NONE, 3'd0, 1'b1, 1'b1);
        end
        rst_n = 1'b0;
        cyc("HLT_RST", 3'd0, 3'd0, NONE, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        fetch();

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
